// File: rtl/reg_dump_pkg.sv
// Shared types and default sizing for the register dump engine.
// W_DEF/D_DEF must track the register file this block reads.
package reg_dump_pkg;

  localparam int W_DEF = 8;
  localparam int D_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump.sv
// Walks a register file from index 0 to N-1 and streams each word out
// over a valid/ready port, with abort and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; ptr parked at 0
// READ  | rdata for ptr is captured into the output register
// SEND  | word presented; waits for out_ready
// DONE  | final word accepted; done pulses this cycle
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int D = D_DEF
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  output logic [D-1:0] raddr,
  input  logic [W-1:0] rdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [D-1:0] out_addr,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  // N = 2**D, so the final index is all ones.
  localparam logic [D-1:0] PTR_LAST = {D{1'b1}};

  state_t       state;
  logic [D-1:0] ptr;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort beats start in IDLE and any handshake elsewhere.
        state     <= ST_IDLE;
        ptr       <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_READ;
              ptr   <= '0;
            end
          end
          ST_READ: begin
            out_data  <= rdata;
            out_addr  <= ptr;
            out_valid <= 1'b1;
            state     <= ST_SEND;
          end
          ST_SEND: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              if (ptr == PTR_LAST) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                ptr   <= ptr + 1'b1;
                state <= ST_READ;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            ptr   <= '0;
          end
          default: begin
            state     <= ST_IDLE;
            ptr       <= '0;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign raddr    = ptr;
  assign busy     = (state != ST_IDLE);
  assign out_last = out_valid && (out_addr == PTR_LAST);

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a table of expected words for full dumps
// plus hand-written stall, restart, abort and async-reset sequences.
module tb_reg_dump;

  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 8;

  typedef struct {
    logic [D-1:0] addr;
    logic [W-1:0] data;
    logic         last;
  } vec_t;

  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b1;
  logic [D-1:0] raddr;
  logic [W-1:0] rdata;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [D-1:0] out_addr;
  logic         out_last;
  logic         busy;
  logic         done;

  logic [W-1:0] regs [N];
  vec_t         tbl  [N];
  logic [11:0]  words[$];
  int           done_cnt = 0;
  int           done_at  = -1;
  int           cyc      = 0;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           start_cyc;
  logic         ok;

  reg_dump #(.W(W), .D(D)) dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .raddr(raddr), .rdata(rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;
  assign rdata = regs[raddr];

  always @(posedge CLK) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge CLK) begin
    if (reset && out_valid && out_ready && !abort)
      words.push_back({out_last, out_addr, out_data});
    if (reset && done) begin
      done_cnt = done_cnt + 1;
      done_at  = cyc;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    words.delete();
    done_cnt = 0;
    done_at  = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid_addr(input logic [D-1:0] a, input string nm);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (out_valid && out_addr == a) ok = 1'b1;
      else step();
    end
    if (!ok) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else step();
    end
    if (!ok) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic check_words(input string nm);
    check({nm, "_count"}, words.size(), N);
    for (int i = 0; i < N && i < words.size(); i++) begin
      check($sformatf("%s_data%0d", nm, i), int'(words[i][7:0]), int'(tbl[i].data));
      check($sformatf("%s_addr%0d", nm, i), int'(words[i][10:8]), int'(tbl[i].addr));
      check($sformatf("%s_last%0d", nm, i), int'(words[i][11]), int'(tbl[i].last));
    end
    check({nm, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      regs[i]      = 8'h10 + 8'(i);
      tbl[i].addr  = 3'(i);
      tbl[i].data  = 8'h10 + 8'(i);
      tbl[i].last  = (i == N - 1);
    end

    // Reset state, before any clock edge
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", out_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_raddr", raddr, 0);
    check("rst_last", out_last, 0);
    step();
    reset = 1'b1;
    step();

    // Full dump with out_ready held high: done in the 17th cycle after start
    clear_log();
    pulse_start();
    check("basic_busy", busy, 1);
    wait_idle("basic");
    check("basic_idle_cycles", cyc - start_cyc, 2 * N + 1);
    check("basic_done_at", done_at - start_cyc, 2 * N);
    check_words("basic");

    // Stall with address 3 on the port for five cycles
    clear_log();
    pulse_start();
    wait_valid_addr(3'd3, "stall");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 8'h13);
      check("stall_addr", out_addr, 3);
      check("stall_raddr", raddr, 3);
      step();
    end
    out_ready = 1'b1;
    wait_idle("stall");
    check_words("stall");

    // Start again mid-dump is ignored
    clear_log();
    pulse_start();
    wait_valid_addr(3'd4, "restart");
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("restart");
    step();
    step();
    check("restart_busy_after", busy, 0);
    check_words("restart");

    // Register changed mid-dump is captured as read, not snapshotted
    clear_log();
    pulse_start();
    wait_valid_addr(3'd1, "live");
    regs[6] = 8'hA6;
    tbl[6].data = 8'hA6;
    wait_idle("live");
    check_words("live");
    regs[6] = 8'h16;
    tbl[6].data = 8'h16;

    // Abort while address 5 is offered with out_ready high
    clear_log();
    pulse_start();
    wait_valid_addr(3'd5, "abort");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_raddr", raddr, 0);
    step();
    step();
    check("abort_done_cnt", done_cnt, 0);
    check("abort_words", words.size(), 5);

    // Start and abort together in IDLE: stays IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);

    clear_log();
    pulse_start();
    step();
    check("after_abort_valid", out_valid, 1);
    check("after_abort_addr", out_addr, 0);
    check("after_abort_data", out_data, 8'h10);
    wait_idle("after_abort");
    check_words("after_abort");

    // Asynchronous reset in the middle of SEND
    clear_log();
    pulse_start();
    wait_valid_addr(3'd2, "areset");
    out_ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("areset_valid", out_valid, 0);
    check("areset_data", out_data, 0);
    check("areset_addr", out_addr, 0);
    check("areset_busy", busy, 0);
    check("areset_raddr", raddr, 0);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    check("areset_idle", busy, 0);
    clear_log();
    pulse_start();
    wait_idle("areset");
    check_words("areset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
